// File: rtl/i8254_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i8254_bus_ctrl
//  Purpose  : Bus interface and control-word stage of an 8254 timer.
//             Decodes CS/RD/WR/A1/A0, holds per-counter control words,
//             assembles LSB/MSB byte writes into 16-bit load strobes and
//             returns latched or live counts on the read data bus.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             data_in/data_out/oe  - CPU data bus (data_out registered)
//             A0, A1, RD, WR, CS   - bus control, strobes active low
//             count_in             - live counts {cnt2,cnt1,cnt0}
//             ctrl_mode, ctrl_bcd  - programmed mode / BCD per counter
//             ctrl_wr              - pulse on control-word write
//             load_strobe/value    - pulse + initial count for a counter
//  Revision : 1.0  initial release
// ============================================================================
module i8254_bus_ctrl #(
    parameter int NCNT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic               data_oe,
    input  logic               A0,
    input  logic               A1,
    input  logic               RD,
    input  logic               WR,
    input  logic               CS,
    input  logic [16*NCNT-1:0] count_in,
    output logic [3*NCNT-1:0]  ctrl_mode,
    output logic [NCNT-1:0]    ctrl_bcd,
    output logic [NCNT-1:0]    ctrl_wr,
    output logic [NCNT-1:0]    load_strobe,
    output logic [15:0]        load_value
);

    localparam logic [1:0] c_addr_ctrl = 2'b11;
    localparam logic [1:0] c_rw_latch  = 2'b00;
    localparam logic [1:0] c_rw_lsb    = 2'b01;
    localparam logic [1:0] c_rw_msb    = 2'b10;
    localparam logic [1:0] c_rw_both   = 2'b11;

    // Per-counter state
    logic [1:0]  r_rw       [NCNT];
    logic [2:0]  r_mode     [NCNT];
    logic        r_bcd      [NCNT];
    logic        r_wptr     [NCNT];   // 0 = next write byte is LSB
    logic        r_rptr     [NCNT];   // 0 = next read byte is LSB
    logic        r_latched  [NCNT];
    logic [15:0] r_latch    [NCNT];
    logic [7:0]  r_lsb_hold [NCNT];

    // Bus edge tracking
    logic        r_wr_d;              // reset to 0: WR held low across reset gives no event
    logic        r_rd_act;            // previous cycle was a valid read cycle
    logic [1:0]  r_rd_addr;

    logic [1:0]  w_addr;
    logic        w_wr_evt;
    logic        w_rd_req;
    logic        w_rd_done;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_src;
    logic [2:0]  w_mode_norm;

    assign w_addr    = {A1, A0};
    assign w_wr_evt  = !CS && !WR && r_wr_d;
    // A simultaneous WR suppresses the read entirely
    assign w_rd_req  = !CS && !RD && WR;
    assign w_rd_done = RD && r_rd_act;
    // Modes 110/111 are aliases of 010/011
    assign w_mode_norm = (data_in[3:2] == 2'b11) ? {1'b0, data_in[2:1]} : data_in[3:1];

    generate
        for (genvar g = 0; g < NCNT; g++) begin : g_out
            assign ctrl_mode[3*g +: 3] = r_mode[g];
            assign ctrl_bcd[g]         = r_bcd[g];
        end
    endgenerate

    // Read byte selection: latched snapshot takes priority over live count
    always_comb begin
        w_rd_byte = 8'h00;
        w_src     = 16'h0000;
        for (int n = 0; n < NCNT; n++) begin
            if (w_addr == 2'(n)) begin
                w_src = r_latched[n] ? r_latch[n] : count_in[16*n +: 16];
                case (r_rw[n])
                    c_rw_lsb:  w_rd_byte = w_src[7:0];
                    c_rw_msb:  w_rd_byte = w_src[15:8];
                    c_rw_both: w_rd_byte = r_rptr[n] ? w_src[15:8] : w_src[7:0];
                    default:   w_rd_byte = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_d      <= 1'b0;
            r_rd_act    <= 1'b0;
            r_rd_addr   <= 2'b00;
            data_out    <= 8'h00;
            data_oe     <= 1'b0;
            ctrl_wr     <= '0;
            load_strobe <= '0;
            load_value  <= 16'h0000;
            for (int n = 0; n < NCNT; n++) begin
                r_rw[n]       <= c_rw_latch;
                r_mode[n]     <= 3'b000;
                r_bcd[n]      <= 1'b0;
                r_wptr[n]     <= 1'b0;
                r_rptr[n]     <= 1'b0;
                r_latched[n]  <= 1'b0;
                r_latch[n]    <= 16'h0000;
                r_lsb_hold[n] <= 8'h00;
            end
        end else begin
            r_wr_d      <= WR;
            r_rd_act    <= w_rd_req;
            r_rd_addr   <= w_addr;
            ctrl_wr     <= '0;
            load_strobe <= '0;

            if (w_rd_req) begin
                data_out <= w_rd_byte;
                data_oe  <= 1'b1;
            end else begin
                data_oe  <= 1'b0;
            end

            // Read completion: advance pointer, drop latch after final byte
            if (w_rd_done) begin
                for (int n = 0; n < NCNT; n++) begin
                    if (r_rd_addr == 2'(n)) begin
                        case (r_rw[n])
                            c_rw_lsb, c_rw_msb: r_latched[n] <= 1'b0;
                            c_rw_both: begin
                                r_rptr[n] <= ~r_rptr[n];
                                if (r_rptr[n])
                                    r_latched[n] <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // Write event; placed after read completion so a latch command
            // in the same cycle wins on latched[n]
            if (w_wr_evt) begin
                for (int n = 0; n < NCNT; n++) begin
                    if (w_addr == c_addr_ctrl) begin
                        if (data_in[7:6] == 2'(n)) begin
                            if (data_in[5:4] == c_rw_latch) begin
                                if (!r_latched[n]) begin
                                    r_latch[n]   <= count_in[16*n +: 16];
                                    r_latched[n] <= 1'b1;
                                end
                            end else begin
                                r_rw[n]      <= data_in[5:4];
                                r_mode[n]    <= w_mode_norm;
                                r_bcd[n]     <= data_in[0];
                                r_latched[n] <= 1'b0;
                                r_wptr[n]    <= 1'b0;
                                r_rptr[n]    <= 1'b0;
                                ctrl_wr[n]   <= 1'b1;
                            end
                        end
                    end else if (w_addr == 2'(n)) begin
                        case (r_rw[n])
                            c_rw_lsb: begin
                                load_value     <= {8'h00, data_in};
                                load_strobe[n] <= 1'b1;
                            end
                            c_rw_msb: begin
                                load_value     <= {data_in, 8'h00};
                                load_strobe[n] <= 1'b1;
                            end
                            c_rw_both: begin
                                if (!r_wptr[n]) begin
                                    r_lsb_hold[n] <= data_in;
                                    r_wptr[n]     <= 1'b1;
                                end else begin
                                    load_value     <= {data_in, r_lsb_hold[n]};
                                    load_strobe[n] <= 1'b1;
                                    r_wptr[n]      <= 1'b0;
                                end
                            end
                            default: ;  // unprogrammed counter ignores writes
                        endcase
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i8254_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i8254_bus_ctrl
//  Purpose  : Directed self-checking bench for i8254_bus_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i8254_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        A0, A1, RD, WR, CS;
    logic [47:0] count_in;
    logic [8:0]  ctrl_mode;
    logic [2:0]  ctrl_bcd;
    logic [2:0]  ctrl_wr;
    logic [2:0]  load_strobe;
    logic [15:0] load_value;

    int checks = 0;
    int errors = 0;

    logic [2:0]  cap_strobe, cap_strobe2, cap_cw, cap_cw2;
    logic [15:0] cap_val;
    logic [7:0]  rdat;
    logic        roe;

    always #5 clk = ~clk;

    i8254_bus_ctrl #(.NCNT(3)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .A0(A0), .A1(A1), .RD(RD), .WR(WR), .CS(CS),
        .count_in(count_in), .ctrl_mode(ctrl_mode), .ctrl_bcd(ctrl_bcd),
        .ctrl_wr(ctrl_wr), .load_strobe(load_strobe), .load_value(load_value)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus write; captures the cycle after the event and the one after that
    task automatic bw(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b0; A1 = a[1]; A0 = a[0]; data_in = d; WR = 1'b0;
        tick();
        cap_strobe = load_strobe; cap_val = load_value; cap_cw = ctrl_wr;
        WR = 1'b1; CS = 1'b1;
        tick();
        cap_strobe2 = load_strobe; cap_cw2 = ctrl_wr;
    endtask

    task automatic br(input logic [1:0] a, output logic [7:0] d, output logic oe);
        CS = 1'b0; A1 = a[1]; A0 = a[0]; RD = 1'b0;
        tick();
        d = data_out; oe = data_oe;
        RD = 1'b1; CS = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; data_in = 8'h00; A0 = 1'b0; A1 = 1'b0;
        RD = 1'b1; WR = 1'b1; CS = 1'b1; count_in = '0;
        tick(); tick(); tick();
        chk("rst_data_out", 16'(data_out), 16'h0000);
        chk("rst_data_oe", 16'(data_oe), 16'h0000);
        chk("rst_ctrl_mode", 16'(ctrl_mode), 16'h0000);
        chk("rst_ctrl_bcd", 16'(ctrl_bcd), 16'h0000);
        chk("rst_ctrl_wr", 16'(ctrl_wr), 16'h0000);
        chk("rst_load_strobe", 16'(load_strobe), 16'h0000);
        chk("rst_load_value", load_value, 16'h0000);
        reset = 1'b0;
        tick();

        // Counter0: RW=11, mode 010, binary
        bw(2'b11, 8'b00110100);
        chk("cw0_pulse", 16'(cap_cw), 16'h0001);
        chk("cw0_pulse_end", 16'(cap_cw2), 16'h0000);
        chk("cw0_mode", 16'(ctrl_mode[2:0]), 16'h0002);
        chk("cw0_bcd", 16'(ctrl_bcd[0]), 16'h0000);
        bw(2'b00, 8'h34);
        chk("w16_lsb_nostrobe", 16'(cap_strobe), 16'h0000);
        bw(2'b00, 8'h12);
        chk("w16_strobe", 16'(cap_strobe), 16'h0001);
        chk("w16_value", cap_val, 16'h1234);
        chk("w16_strobe_end", 16'(cap_strobe2), 16'h0000);

        // Counter1: LSB only, mode 111 -> 011, BCD
        bw(2'b11, 8'b01011111);
        chk("cw1_pulse", 16'(cap_cw), 16'h0002);
        chk("cw1_mode_norm", 16'(ctrl_mode[5:3]), 16'h0003);
        chk("cw1_bcd", 16'(ctrl_bcd[1]), 16'h0001);
        chk("cw1_mode0_kept", 16'(ctrl_mode[2:0]), 16'h0002);
        bw(2'b01, 8'hAB);
        chk("w8lsb_strobe", 16'(cap_strobe), 16'h0002);
        chk("w8lsb_value", cap_val, 16'h00AB);

        // Latch on counter0 then count moves on
        count_in[15:0] = 16'hBEEF;
        bw(2'b11, 8'h00);
        chk("latch_no_cw", 16'(cap_cw), 16'h0000);
        count_in[15:0] = 16'h1111;
        br(2'b00, rdat, roe);
        chk("latch_rd_lsb", 16'(rdat), 16'h00EF);
        chk("latch_rd_oe", 16'(roe), 16'h0001);
        chk("rd_oe_drops", 16'(data_oe), 16'h0000);
        br(2'b00, rdat, roe);
        chk("latch_rd_msb", 16'(rdat), 16'h00BE);
        br(2'b00, rdat, roe);
        chk("live_rd_lsb", 16'(rdat), 16'h0011);

        // Double latch on counter2: second ignored
        bw(2'b11, 8'b10110000);
        count_in[47:32] = 16'h5678;
        bw(2'b11, 8'h80);
        count_in[47:32] = 16'h9ABC;
        bw(2'b11, 8'h80);
        br(2'b10, rdat, roe);
        chk("dbl_latch_lsb", 16'(rdat), 16'h0078);
        br(2'b10, rdat, roe);
        chk("dbl_latch_msb", 16'(rdat), 16'h0056);

        // Control word between LSB and MSB resets write pointer
        bw(2'b11, 8'b00110100);
        bw(2'b00, 8'h11);
        bw(2'b11, 8'b00110100);
        bw(2'b00, 8'h22);
        chk("ptr_reset_nostrobe", 16'(cap_strobe), 16'h0000);
        bw(2'b00, 8'h33);
        chk("ptr_reset_strobe", 16'(cap_strobe), 16'h0001);
        chk("ptr_reset_value", cap_val, 16'h3322);

        // Counter1: MSB only
        bw(2'b11, 8'b01100000);
        count_in[31:16] = 16'h4321;
        br(2'b01, rdat, roe);
        chk("msb_read", 16'(rdat), 16'h0043);
        bw(2'b01, 8'hCD);
        chk("msb_strobe", 16'(cap_strobe), 16'h0002);
        chk("msb_value", cap_val, 16'hCD00);
        br(2'b11, rdat, roe);
        chk("ctrl_addr_read", 16'(rdat), 16'h0000);

        // WR and RD low together: write happens, no read output
        CS = 1'b0; A1 = 1'b0; A0 = 1'b0; data_in = 8'h77; WR = 1'b0; RD = 1'b0;
        tick();
        chk("wr_rd_oe", 16'(data_oe), 16'h0000);
        WR = 1'b1; RD = 1'b1; CS = 1'b1;
        tick();
        bw(2'b00, 8'h88);
        chk("wr_rd_write_done", cap_val, 16'h8877);
        chk("wr_rd_write_strobe", 16'(cap_strobe), 16'h0001);

        // Reset after first byte
        bw(2'b00, 8'h55);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        bw(2'b00, 8'h66);
        chk("post_rst_wr_ignored", 16'(cap_strobe), 16'h0000);
        chk("post_rst_wr_ignored2", 16'(cap_strobe2), 16'h0000);
        br(2'b00, rdat, roe);
        chk("post_rst_read", 16'(rdat), 16'h0000);

        // WR held low through reset release: no event
        CS = 1'b0; A1 = 1'b1; A0 = 1'b1; data_in = 8'b00110100; WR = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("held_wr_no_cw_a", 16'(ctrl_wr), 16'h0000);
        tick();
        chk("held_wr_no_cw_b", 16'(ctrl_wr), 16'h0000);
        WR = 1'b1; CS = 1'b1;
        tick();
        chk("held_wr_mode", 16'(ctrl_mode), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
